// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - fixed-priority interrupt controller with mask/mode/pending registers and IDLE/REQ/SERV handshake
module int_ctrl #(
    parameter int NSRC     = 6,
    parameter bit EOI_AUTO = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic [1:0]      reg_addr,
    input  logic            reg_we,
    input  logic [31:0]     reg_wd,
    output logic [31:0]     reg_rd,
    output logic            int_req,
    output logic [2:0]      int_id,
    input  logic            int_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [NSRC-1:0] mask, mode, pend, prev;
    logic [NSRC-1:0] pend_next, elig, id_onehot, clr;
    logic [2:0]      winner;
    logic            load_id, ack_take, id_elig;
    logic            wr_mask, wr_mode, wr_pend, wr_eoi;
    logic            unused_wd;

    assign unused_wd = ^reg_wd[31:NSRC];

    assign wr_mask  = reg_we && (reg_addr == 2'd0);
    assign wr_mode  = reg_we && (reg_addr == 2'd1);
    assign wr_pend  = reg_we && (reg_addr == 2'd2);
    assign wr_eoi   = reg_we && (reg_addr == 2'd3);
    assign ack_take = int_ack && (state == REQ);
    assign elig     = pend & mask;
    assign id_elig  = |(elig & id_onehot);
    assign int_req  = (state == REQ);

    always_comb begin
        winner = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) winner = 3'(i);
        end
        for (int i = 0; i < NSRC; i++) begin
            id_onehot[i] = (int_id == 3'(i));
        end
    end

    // Edge bits: a fresh rising edge beats any clear (W1C or ack) in the same cycle.
    always_comb begin
        clr = (wr_pend ? reg_wd[NSRC-1:0] : '0) | (ack_take ? id_onehot : '0);
        for (int i = 0; i < NSRC; i++) begin
            if (mode[i]) pend_next[i] = (irq_in[i] & ~prev[i]) | (pend[i] & ~clr[i]);
            else         pend_next[i] = irq_in[i];
        end
    end

    always_comb begin
        state_next = state;
        load_id    = 1'b0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_next = REQ;
                    load_id    = 1'b1;
                end
            end
            REQ: begin
                if (int_ack)       state_next = EOI_AUTO ? IDLE : SERV;
                else if (!id_elig) state_next = IDLE;
            end
            SERV: begin
                if (wr_eoi) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            int_id <= 3'd0;
        end else begin
            state <= state_next;
            if (load_id) int_id <= winner;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
            mode <= '0;
            pend <= '0;
            prev <= '0;
        end else begin
            prev <= irq_in;
            pend <= pend_next;
            if (wr_mask) mask <= reg_wd[NSRC-1:0];
            if (wr_mode) mode <= reg_wd[NSRC-1:0];
        end
    end

    always_comb begin
        case (reg_addr)
            2'd0:    reg_rd = 32'(mask);
            2'd1:    reg_rd = 32'(mode);
            2'd2:    reg_rd = 32'(pend);
            default: reg_rd = {22'd0, state, 5'd0, int_id};
        endcase
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NSRC, default 6, number of interrupt sources; equals the CPU hardware-interrupt field width.
REQ-002 Parameter EOI_AUTO, default 0; 1 means the ack also ends service, with no EOI write.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 irq_in  input  NSRC  raw device interrupt lines (timer IRQs and others), synchronous to clk.
REQ-006 reg_addr  input  2  register word select: 0 MASK, 1 MODE, 2 PEND, 3 STAT/EOI.
REQ-007 reg_we  input  1  register write strobe, one cycle per write.
REQ-008 reg_wd  input  32  register write data; only bits [NSRC-1:0] are used.
REQ-009 reg_rd  output  32  register read data, combinational from reg_addr; unused bits read 0.
REQ-010 int_req  output  1  interrupt request to the CPU.
REQ-011 int_id  output  3  index of the requested or in-service source.
REQ-012 int_ack  input  1  one-cycle pulse from the CPU on taking the exception.

Function
REQ-013 MASK[i]=1 enables source i; MODE[i]=1 selects edge mode, 0 selects level mode.
REQ-014 Edge mode: the block keeps a registered copy of irq_in (prev); a cycle with irq_in[i]=1 and prev[i]=0 sets PEND[i] on that clock edge.
REQ-015 Level mode: PEND[i] shall follow irq_in[i], registered, one cycle of latency.
REQ-016 Writing PEND clears, for edge-mode bits only, each bit written 1 (W1C); in the same cycle, a new edge wins over the clear.
REQ-017 Eligible set E = PEND & MASK; the winner is the lowest index in E (fixed priority, bit 0 highest).
REQ-018 FSM states: IDLE, REQ, SERV; int_req=1 only in REQ.
REQ-019 IDLE: if E is non-zero, go to REQ on the next edge and latch the winner into int_id; int_req rises one cycle after PEND sets.
REQ-020 REQ: int_id is held, with no re-arbitration, even if a higher-priority source becomes eligible.
REQ-021 REQ with int_ack=1: clear PEND[int_id] if it is edge mode, then go to SERV, or to IDLE when EOI_AUTO=1.
REQ-022 REQ with int_ack=0 and the latched source no longer eligible (masked, W1C-cleared, or level dropped): return to IDLE and drop int_req; int_ack has priority in that same cycle.
REQ-023 SERV: int_req=0 and int_id is held; no nesting; new edges still accumulate in PEND.
REQ-024 SERV: a write to address 3 (EOI, data ignored) returns to IDLE; arbitration resumes the next cycle.
REQ-025 An EOI write outside SERV, and int_ack outside REQ, shall have no effect.
REQ-026 STAT read = {state[1:0] at bits 9:8, int_id at bits 2:0}, with IDLE=0, REQ=1, SERV=2.
REQ-027 A register write and a state transition in the same cycle both take effect; a write applies to the next cycle's E.

Reset
REQ-028 Reset shall force MASK=0, MODE=0, PEND=0, prev=0, state=IDLE, int_req=0, int_id=0, asynchronously.
REQ-029 Reset asserted during REQ or SERV shall abandon service immediately; int_req shall be 0 in the same cycle.

Verification
REQ-030 Edge basics: MASK=0x3F, MODE=0x01, pulse irq_in[0] -> int_req=1 and int_id=0 one cycle after PEND[0] sets; ack -> PEND[0]=0, STAT state=2; EOI -> state=0.
REQ-031 Priority: irq_in[4] and irq_in[1] rise together (both edge mode) -> int_id=1; after ack and EOI -> int_id=4 is requested next.
REQ-032 Level withdraw: MODE=0, irq_in[2] held high, then dropped while in REQ without ack -> int_req returns to 0 within 2 cycles and state=IDLE.
REQ-033 Masking: MASK=0, irq_in[3] edge -> PEND[3]=1 and int_req stays 0; writing MASK=0x08 -> int_req=1 and int_id=3.
REQ-034 Collision: a W1C clear of PEND[5] in the same cycle as a new edge on irq_in[5] -> PEND[5] stays 1; an EOI in IDLE -> no state change.
REQ-035 Reset in SERV: assert reset mid-service -> every register reads 0 and int_req=0 immediately; after release, no request until a new edge.
